// File: rtl/vend_credit_controller.sv
// vend_credit_controller: coin credit accumulator with one-cycle dispense pulse and nickel change return.
// Define VEND_COUNT_EN to add a saturating 16-bit vend_count output.
module vend_credit_controller #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 7
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                cancel,
  output logic                open,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic                busy,
`ifdef VEND_COUNT_EN
  output logic [15:0]         vend_count,
`endif
  output logic [CREDIT_W-1:0] credit
);
  typedef enum logic [1:0] {ACCUM, VEND, CHANGE} state_t;
  localparam logic [CREDIT_W-1:0] P_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] C25     = CREDIT_W'(25);
  state_t              r_state, w_state;
  logic [CREDIT_W-1:0] r_credit, w_credit, w_value, w_total;
  logic                r_phase, w_phase, r_coin_reject, w_coin_reject;
  logic [1:0]          w_ncoins;
  always_comb begin
    w_ncoins      = {1'b0, N} + {1'b0, D} + {1'b0, Q};
    w_value       = N ? C5 : D ? C10 : C25;
    w_total       = r_credit + w_value;
    w_state       = r_state;
    w_credit      = r_credit;
    w_phase       = (r_state == CHANGE) ? ~r_phase : 1'b0;
    // cancel outranks a simultaneous coin, so that coin is bounced
    w_coin_reject = (r_state != ACCUM || cancel) ? (w_ncoins != 2'd0) : (w_ncoins > 2'd1);
    case (r_state)
      ACCUM:
        if (cancel)
          w_state = (r_credit != '0) ? CHANGE : ACCUM;
        else if (w_ncoins == 2'd1) begin
          w_credit = (w_total >= P_PRICE) ? w_total - P_PRICE : w_total;
          w_state  = (w_total >= P_PRICE) ? VEND : ACCUM;
        end
      VEND:
        w_state = (r_credit != '0) ? CHANGE : ACCUM;
      CHANGE: begin
        w_credit = r_phase ? r_credit : r_credit - C5;
        w_state  = (r_phase && r_credit == '0) ? ACCUM : CHANGE;
      end
      default:
        w_state = ACCUM;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ACCUM;
      r_credit      <= '0;
      r_phase       <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_credit      <= w_credit;
      r_phase       <= w_phase;
      r_coin_reject <= w_coin_reject;
    end
  end
  assign open          = (r_state == VEND);
  assign change_nickel = (r_state == CHANGE) && !r_phase;
  assign busy          = (r_state != ACCUM);
  assign coin_reject   = r_coin_reject;
  assign credit        = r_credit;
`ifdef VEND_COUNT_EN
  logic [15:0] r_vend_count;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_vend_count <= '0;
    else if (w_state == VEND && r_vend_count != 16'hFFFF)
      r_vend_count <= r_vend_count + 16'd1;
  end
  assign vend_count = r_vend_count;
`endif
endmodule

// File: tb/tb_vend_credit_controller.sv
// tb_vend_credit_controller: directed and random coin traffic checked against a transaction-level credit model.
module tb_vend_credit_controller;
  localparam int PRICE = 15;
  localparam int CREDIT_W = 7;
  logic clk, rstn, N, D, Q, cancel;
  logic open, change_nickel, coin_reject, busy;
  logic [CREDIT_W-1:0] credit;
  logic [15:0] vend_count;
  int n_vec, n_bad;
  // Model: idle credit, or a busy episode of m_len cycles (optional vend cycle, then 2 cycles per nickel).
  int m_credit, m_base, m_k, m_len, m_vend, m_rej, m_count;

  vend_credit_controller #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
    .clk(clk), .rstn(rstn), .N(N), .D(D), .Q(Q), .cancel(cancel),
    .open(open), .change_nickel(change_nickel), .coin_reject(coin_reject), .busy(busy),
`ifdef VEND_COUNT_EN
    .vend_count(vend_count),
`endif
    .credit(credit)
  );
`ifndef VEND_COUNT_EN
  assign vend_count = '0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_credit = 0; m_base = 0; m_k = 0; m_len = 0; m_vend = 0; m_rej = 0; m_count = 0;
  endtask

  task automatic start_busy(input int base, input int vend);
    m_base = base; m_vend = vend; m_k = 0; m_len = vend + 2 * (base / 5); m_credit = 0;
  endtask

  task automatic step(input bit n, input bit d, input bit q, input bit c);
    int nc, tot;
    nc = int'(n) + int'(d) + int'(q);
    if (m_k < m_len) begin
      m_rej = (nc > 0);
      m_k++;
    end else begin
      m_rej = (nc > 1) || (c && nc > 0);
      if (c) begin
        if (m_credit > 0) start_busy(m_credit, 0);
      end else if (nc == 1) begin
        tot = m_credit + (n ? 5 : d ? 10 : 25);
        if (tot >= PRICE) begin
          start_busy(tot - PRICE, 1);
          if (m_count < 65535) m_count++;
        end else m_credit = tot;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int j;
    bit b;
    b = (m_k < m_len);
    j = m_k - m_vend;
    check("busy", 32'(busy), 32'(b));
    check("open", 32'(open), 32'(b && m_vend == 1 && m_k == 0));
    check("change_nickel", 32'(change_nickel), 32'(b && j >= 0 && j % 2 == 0));
    check("coin_reject", 32'(coin_reject), 32'(m_rej));
    check("credit", 32'(credit), 32'(!b ? m_credit : (j < 0 ? m_base : m_base - 5 * ((j + 1) / 2))));
`ifdef VEND_COUNT_EN
    check("vend_count", 32'(vend_count), 32'(m_count));
`endif
  endtask

  task automatic cyc(input bit n, input bit d, input bit q, input bit c);
    @(negedge clk);
    check_all();
    N = n; D = d; Q = q; cancel = c;
    @(posedge clk);
    step(n, d, q, c);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic hit_reset();
    @(negedge clk);
    check_all();
    N = 0; D = 0; Q = 0; cancel = 0;
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    #2 rstn = 1'b1;
    @(posedge clk);
    step(0, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    N = 0; D = 0; Q = 0; cancel = 0;
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    #2 rstn = 1'b1;
    @(posedge clk);
    step(0, 0, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(3);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); idle(4);
    cyc(0, 0, 1, 0); idle(6);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 1); idle(4);
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 1); idle(4);
    cyc(0, 1, 0, 1); idle(2);
    cyc(1, 1, 0, 0); idle(2);
    cyc(1, 1, 1, 0); idle(2);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 0); idle(6);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); idle(10);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    hit_reset();
    idle(4);
    for (int v = 0; v < 3; v++) begin
      cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); idle(2);
    end
    hit_reset();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 15) == 0);
    idle(12);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
